// File: rtl/puf_eval_sequencer.sv
// puf_eval_sequencer: frame-driven PUF challenge/response sequencer.
// Pulls a header plus challenge bytes from a UART RX FIFO, drives the PUF,
// waits for the response (bounded by a timeout), then streams a status
// byte and the captured response into a UART TX FIFO.
module puf_eval_sequencer #(
   parameter int         CHAL_BYTES     = 16,
   parameter int         RESP_BYTES     = 16,
   parameter int         TIMEOUT_CYCLES = 65535,
   parameter logic [7:0] HDR_CHAL       = 8'h43,
   parameter logic [7:0] HDR_OK         = 8'h52,
   parameter logic [7:0] HDR_TO         = 8'h54
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              rx_data,
   input  logic                    rx_data_present,
   output logic                    rx_read,
   output logic [7:0]              tx_data,
   output logic                    tx_write,
   input  logic                    tx_full,
   output logic [CHAL_BYTES*8-1:0] chal,
   output logic                    chal_en,
   output logic                    puf_start,
   input  logic                    response_ready,
   input  logic [RESP_BYTES*8-1:0] resp,
   output logic                    busy,
   output logic                    timeout_err
);

   localparam logic [3:0]  LAST_CHAL = 4'(CHAL_BYTES - 1);
   localparam logic [3:0]  LAST_RESP = 4'(RESP_BYTES - 1);
   localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_APPLY,
      S_START,
      S_WAIT,
      S_SEND_HDR,
      S_SEND_RESP
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic                    r_gap;          // a pop happened last cycle
   logic [3:0]              r_idx;          // challenge / response byte index
   logic [15:0]             r_cnt;          // WAIT cycle counter
   logic                    r_status_ok;    // 1: response captured, 0: timed out
   logic                    r_timeout_err;
   logic [RESP_BYTES*8-1:0] r_resp;
   logic [7:0]              r_chal_b [CHAL_BYTES];
   logic [7:0]              w_resp_byte [RESP_BYTES];
   logic                    w_pop_ok;

   assign w_pop_ok    = rx_data_present && !r_gap;
   assign timeout_err = r_timeout_err;

   // Byte views of the captured response and the challenge register
   for (genvar gi = 0; gi < RESP_BYTES; gi++) begin : g_resp
      assign w_resp_byte[gi] = r_resp[gi*8 +: 8];
   end
   for (genvar gi = 0; gi < CHAL_BYTES; gi++) begin : g_chal
      assign chal[gi*8 +: 8] = r_chal_b[gi];
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Next state and strobes; all strobes are forced low while in reset so
   // an interrupted reply never emits another byte.
   always_comb begin
      w_state_next = r_state;
      rx_read      = 1'b0;
      tx_write     = 1'b0;
      tx_data      = 8'h00;
      chal_en      = 1'b0;
      puf_start    = 1'b0;
      busy         = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (w_pop_ok) begin
               rx_read = 1'b1;
               if (rx_data == HDR_CHAL) w_state_next = S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_pop_ok) begin
               rx_read = 1'b1;
               if (r_idx == LAST_CHAL) w_state_next = S_APPLY;
            end
         end
         S_APPLY: begin
            chal_en      = 1'b1;
            w_state_next = S_START;
         end
         S_START: begin
            puf_start    = 1'b1;
            w_state_next = S_WAIT;
         end
         S_WAIT: begin
            puf_start = 1'b1;
            if (response_ready || r_cnt == CNT_LAST) w_state_next = S_SEND_HDR;
         end
         S_SEND_HDR: begin
            tx_data = r_status_ok ? HDR_OK : HDR_TO;
            if (!tx_full) begin
               tx_write     = 1'b1;
               w_state_next = r_status_ok ? S_SEND_RESP : S_IDLE;
            end
         end
         S_SEND_RESP: begin
            tx_data = w_resp_byte[r_idx];
            if (!tx_full) begin
               tx_write = 1'b1;
               if (r_idx == LAST_RESP) w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
      if (rst) begin
         rx_read   = 1'b0;
         tx_write  = 1'b0;
         tx_data   = 8'h00;
         chal_en   = 1'b0;
         puf_start = 1'b0;
         busy      = 1'b0;
      end
   end

   // Datapath: pop spacing, byte index, timeout counter, response capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gap         <= 1'b0;
         r_idx         <= '0;
         r_cnt         <= '0;
         r_status_ok   <= 1'b0;
         r_timeout_err <= 1'b0;
         r_resp        <= '0;
      end else begin
         r_gap <= rx_read;
         case (r_state)
            S_IDLE: begin
               if (rx_read && rx_data == HDR_CHAL) begin
                  r_timeout_err <= 1'b0;
                  r_idx         <= '0;
               end
            end
            S_LOAD: begin
               if (rx_read && r_idx != LAST_CHAL) r_idx <= r_idx + 4'd1;
            end
            S_START: r_cnt <= '0;
            S_WAIT: begin
               r_cnt <= r_cnt + 16'd1;
               if (response_ready) begin
                  r_resp      <= resp;
                  r_status_ok <= 1'b1;
               end else if (r_cnt == CNT_LAST) begin
                  r_status_ok   <= 1'b0;
                  r_timeout_err <= 1'b1;
               end
            end
            S_SEND_HDR: begin
               if (tx_write) r_idx <= '0;
            end
            S_SEND_RESP: begin
               if (tx_write) r_idx <= r_idx + 4'd1;
            end
            default: ;
         endcase
      end
   end

   // Challenge register: written only while loading, held between frames
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < CHAL_BYTES; k++) r_chal_b[k] <= 8'h00;
      end else if (r_state == S_LOAD && rx_read) begin
         r_chal_b[r_idx] <= rx_data;
      end
   end

endmodule
